// File: rtl/fft_pkg.sv
// Shared types and constants for the 32-point radix-2 DIT FFT sequencer.
// Also holds the butterfly address helper used by the issue logic.
package fft_pkg;

    localparam int N_POINTS = 32;
    localparam int LOG2_N   = 5;
    localparam int TW_W     = 16;
    localparam int N_BFLY   = N_POINTS / 2;

    typedef logic [LOG2_N-1:0] fft_addr_t;
    typedef logic [LOG2_N-2:0] fft_bfly_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fft_seq_state_t;

    typedef struct packed {
        fft_addr_t a;
        fft_addr_t b;
        fft_addr_t tw;
    } fft_bfly_addr_t;

    // Operand pair and forward twiddle index of butterfly j in stage s.
    // The top operand is the group base (grp * 2 * span) plus the position
    // inside the group; the bottom operand sits one span above it.
    function automatic fft_bfly_addr_t fft_bfly_addr(input logic [2:0] s, input fft_bfly_t j);
        fft_addr_t      span;
        fft_addr_t      jx;
        fft_addr_t      pos;
        fft_addr_t      grp;
        fft_bfly_addr_t res;
        jx      = {1'b0, j};
        span    = fft_addr_t'(1'b1) << s;
        pos     = jx & (span - fft_addr_t'(1'b1));
        grp     = jx >> s;
        res.a   = (grp << (s + 3'd1)) | pos;
        res.b   = res.a + span;
        res.tw  = pos << (3'(LOG2_N - 1) - s);
        return res;
    endfunction

endpackage

// File: rtl/fft_seq_delay_line.sv
// Fixed-latency replay of {rd_en, rd_addr_a, rd_addr_b} so that write-back
// addresses line up with the butterfly datapath output. Never stalls.
module fft_seq_delay_line
    import fft_pkg::*;
#(
    parameter int DEPTH = 3
)
(
    input  logic      clk,
    input  logic      rst,
    input  logic      i_vld,
    input  fft_addr_t i_addr_a,
    input  fft_addr_t i_addr_b,
    output logic      o_vld,
    output fft_addr_t o_addr_a,
    output fft_addr_t o_addr_b
);

    logic      r_vld    [DEPTH];
    fft_addr_t r_addr_a [DEPTH];
    fft_addr_t r_addr_b [DEPTH];

    // Shift every cycle; reset wipes in-flight entries so no stale write-back escapes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_vld[i]    <= 1'b0;
                r_addr_a[i] <= '0;
                r_addr_b[i] <= '0;
            end
        end else begin
            r_vld[0]    <= i_vld;
            r_addr_a[0] <= i_addr_a;
            r_addr_b[0] <= i_addr_b;
            for (int i = 1; i < DEPTH; i++) begin
                r_vld[i]    <= r_vld[i-1];
                r_addr_a[i] <= r_addr_a[i-1];
                r_addr_b[i] <= r_addr_b[i-1];
            end
        end
    end

    assign o_vld    = r_vld[DEPTH-1];
    assign o_addr_a = r_addr_a[DEPTH-1];
    assign o_addr_b = r_addr_b[DEPTH-1];

endmodule

// File: rtl/fft_stage_sequencer.sv
// Address/control sequencer for an in-place 32-point radix-2 DIT FFT
// (data pre-loaded in bit-reversed order). Walks 5 stages x 16 butterflies,
// issues operand reads and twiddle indices, replays write-back addresses
// after BFLY_LATENCY cycles and drains the pipeline between stages.
// Optional feature macro: FFT_SEQ_INVERSE_EN (adds i_inverse, conjugated twiddles).
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int BFLY_LATENCY = 3
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic                i_hold,
`ifdef FFT_SEQ_INVERSE_EN
    input  logic                i_inverse,
`endif
    output logic                o_busy,
    output logic                o_done,
    output logic                o_rd_en,
    output logic [LOG2_N-1:0]   o_rd_addr_a,
    output logic [LOG2_N-1:0]   o_rd_addr_b,
    output logic [LOG2_N-1:0]   o_tw_idx,
    output logic [2:0]          o_stage,
    output logic                o_wr_en,
    output logic [LOG2_N-1:0]   o_wr_addr_a,
    output logic [LOG2_N-1:0]   o_wr_addr_b
);

    localparam logic [2:0] LAST_STAGE = 3'(LOG2_N - 1);
    localparam fft_bfly_t  LAST_BFLY  = fft_bfly_t'(N_BFLY - 1);
    localparam logic [7:0] DRAIN_LAST = 8'(BFLY_LATENCY - 1);

    fft_seq_state_t r_state;
    logic [2:0]     r_stage;
    fft_bfly_t      r_bfly;
    logic [7:0]     r_drain_cnt;
    logic           r_busy;
    logic           r_done;
    logic           r_rd_en;
    fft_addr_t      r_rd_addr_a;
    fft_addr_t      r_rd_addr_b;
    fft_addr_t      r_tw_idx;
`ifdef FFT_SEQ_INVERSE_EN
    logic           r_inverse;
`endif

    fft_bfly_addr_t w_addr;
    fft_addr_t      w_tw;

    assign w_addr = fft_bfly_addr(r_stage, r_bfly);

    // Select forward twiddle or its conjugate (N - k) mod N; k = 0 stays 0.
    always_comb begin
        w_tw = w_addr.tw;
`ifdef FFT_SEQ_INVERSE_EN
        if (r_inverse) begin
            w_tw = fft_addr_t'(1'b0) - w_addr.tw;
        end else begin
            w_tw = w_addr.tw;
        end
`endif
    end

    // Main sequencer FSM: issue, drain, done handshake; all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_stage     <= 3'd0;
            r_bfly      <= '0;
            r_drain_cnt <= 8'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd_addr_a <= '0;
            r_rd_addr_b <= '0;
            r_tw_idx    <= '0;
`ifdef FFT_SEQ_INVERSE_EN
            r_inverse   <= 1'b0;
`endif
        end else begin
            r_busy <= (r_state == ISSUE) || (r_state == DRAIN);
            r_done <= (r_state == DONE);
            case (r_state)
                IDLE: begin
                    r_rd_en <= 1'b0;
                    if (i_start) begin
                        r_state     <= ISSUE;
                        r_stage     <= 3'd0;
                        r_bfly      <= '0;
                        r_drain_cnt <= 8'd0;
`ifdef FFT_SEQ_INVERSE_EN
                        r_inverse   <= i_inverse;
`endif
                    end else begin
                        r_state <= IDLE;
                    end
                end
                ISSUE: begin
                    if (i_hold) begin
                        // Stall: no read this cycle, counter frozen.
                        r_rd_en <= 1'b0;
                    end else begin
                        r_rd_en     <= 1'b1;
                        r_rd_addr_a <= w_addr.a;
                        r_rd_addr_b <= w_addr.b;
                        r_tw_idx    <= w_tw;
                        if (r_bfly == LAST_BFLY) begin
                            r_state     <= DRAIN;
                            r_bfly      <= '0;
                            r_drain_cnt <= 8'd0;
                        end else begin
                            r_bfly <= r_bfly + fft_bfly_t'(1'b1);
                        end
                    end
                end
                DRAIN: begin
                    // Wait until the stage's last write-back has been issued
                    // so the next stage never reads a stale operand.
                    r_rd_en <= 1'b0;
                    if (r_drain_cnt == DRAIN_LAST) begin
                        r_drain_cnt <= 8'd0;
                        if (r_stage == LAST_STAGE) begin
                            r_state <= DONE;
                        end else begin
                            r_state <= ISSUE;
                            r_stage <= r_stage + 3'd1;
                        end
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 8'd1;
                    end
                end
                DONE: begin
                    r_rd_en <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_rd_en <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    fft_seq_delay_line #(
        .DEPTH    (BFLY_LATENCY)
    ) u_delay (
        .clk      (clk),
        .rst      (rst),
        .i_vld    (r_rd_en),
        .i_addr_a (r_rd_addr_a),
        .i_addr_b (r_rd_addr_b),
        .o_vld    (o_wr_en),
        .o_addr_a (o_wr_addr_a),
        .o_addr_b (o_wr_addr_b)
    );

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_rd_en     = r_rd_en;
    assign o_rd_addr_a = r_rd_addr_a;
    assign o_rd_addr_b = r_rd_addr_b;
    assign o_tw_idx    = r_tw_idx;
    assign o_stage     = r_stage;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer: address order, timing, hold,
// start filtering, mid-transform reset and (if FFT_SEQ_INVERSE_EN) inverse twiddles.
module tb_fft_stage_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_start = 1'b0;
    logic       i_hold = 1'b0;
`ifdef FFT_SEQ_INVERSE_EN
    logic       i_inverse = 1'b0;
`endif
    logic       o_busy, o_done, o_rd_en, o_wr_en;
    logic [4:0] o_rd_addr_a, o_rd_addr_b, o_tw_idx, o_wr_addr_a, o_wr_addr_b;
    logic [2:0] o_stage;

    int n_chk = 0;
    int n_bad = 0;
    int cap_a [80];
    int cap_b [80];
    int cap_tw[80];

    always #5 clk = ~clk;

    fft_stage_sequencer #(.BFLY_LATENCY(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_hold      (i_hold),
`ifdef FFT_SEQ_INVERSE_EN
        .i_inverse   (i_inverse),
`endif
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_rd_en     (o_rd_en),
        .o_rd_addr_a (o_rd_addr_a),
        .o_rd_addr_b (o_rd_addr_b),
        .o_tw_idx    (o_tw_idx),
        .o_stage     (o_stage),
        .o_wr_en     (o_wr_en),
        .o_wr_addr_a (o_wr_addr_a),
        .o_wr_addr_b (o_wr_addr_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Reference tuple of issue number idx (stage-major, butterfly-minor).
    function automatic void bfly_ref(input int idx, input bit inv,
                                     output int s, output int a, output int b, output int tw);
        int j, span, pos, grp, k;
        s    = idx / 16;
        j    = idx % 16;
        span = 1 << s;
        pos  = j % span;
        grp  = j / span;
        a    = grp * 2 * span + pos;
        b    = a + span;
        k    = pos * (16 / span);
        tw   = inv ? (32 - k) % 32 : k;
    endfunction

    // rd_en window with no hold: stage s issues at 1+19s .. 16+19s.
    function automatic bit rd_window(input int c);
        bit r = 1'b0;
        for (int s = 0; s < 5; s++) begin
            if (c >= 1 + 19 * s && c <= 16 + 19 * s) r = 1'b1;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transform from a start seen at edge 0, observed for 130 cycles.
    task automatic run_xform(input int hold_from, input int hold_len, input int restart_at,
                             input int done_start, input int exp_done, input bit inv);
        logic       h_en [0:131];
        logic [4:0] h_a  [0:131];
        logic [4:0] h_b  [0:131];
        int n_issue = 0;
        int n_done  = 0;
        int done_at = -1;
        int s, a, b, tw;
        logic hs, e_wr;
`ifdef FFT_SEQ_INVERSE_EN
        i_inverse = inv;
`endif
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        h_en[0] = o_rd_en; h_a[0] = o_rd_addr_a; h_b[0] = o_rd_addr_b;
        for (int c = 1; c <= 130; c++) begin
            hs      = (c >= hold_from) && (c < hold_from + hold_len);
            i_hold  = hs;
            i_start = (c == restart_at) || (c == done_start);
            step();
            h_en[c] = o_rd_en; h_a[c] = o_rd_addr_a; h_b[c] = o_rd_addr_b;
            if (hold_len == 0) check_eq("rd_timing", o_rd_en, rd_window(c));
            if (hs) check_eq("hold_gap", o_rd_en, 1'b0);
            if (o_rd_en) begin
                if (n_issue < 80) begin
                    bfly_ref(n_issue, inv, s, a, b, tw);
                    check_eq("rd_a", o_rd_addr_a, a);
                    check_eq("rd_b", o_rd_addr_b, b);
                    check_eq("tw", o_tw_idx, tw);
                    check_eq("stage", o_stage, s);
                    cap_a[n_issue] = o_rd_addr_a;
                    cap_b[n_issue] = o_rd_addr_b;
                    cap_tw[n_issue] = o_tw_idx;
                end
                n_issue++;
            end
            e_wr = (c >= 3) ? h_en[c-3] : 1'b0;
            check_eq("wr_en", o_wr_en, e_wr);
            if (c >= 3 && e_wr) begin
                check_eq("wr_a", o_wr_addr_a, h_a[c-3]);
                check_eq("wr_b", o_wr_addr_b, h_b[c-3]);
            end
            if (o_done) begin
                n_done++;
                done_at = c;
            end
            if (c == 10) check_eq("busy_mid", o_busy, 1'b1);
            if (c == exp_done + 1) check_eq("busy_end", o_busy, 1'b0);
        end
        i_hold  = 1'b0;
        i_start = 1'b0;
        check_eq("n_issue", n_issue, 80);
        check_eq("n_done", n_done, 1);
        check_eq("done_cycle", done_at, exp_done);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"}, o_busy, 1'b0);
        check_eq({tag, "_done"}, o_done, 1'b0);
        check_eq({tag, "_rd_en"}, o_rd_en, 1'b0);
        check_eq({tag, "_rd_a"}, o_rd_addr_a, 5'd0);
        check_eq({tag, "_rd_b"}, o_rd_addr_b, 5'd0);
        check_eq({tag, "_tw"}, o_tw_idx, 5'd0);
        check_eq({tag, "_stage"}, o_stage, 3'd0);
        check_eq({tag, "_wr_en"}, o_wr_en, 1'b0);
        check_eq({tag, "_wr_a"}, o_wr_addr_a, 5'd0);
        check_eq({tag, "_wr_b"}, o_wr_addr_b, 5'd0);
    endtask

    initial begin
        int n_wr, n_rd;
        // Reset state.
        step();
        step();
        check_idle_outputs("reset");
        rst = 1'b0;
        step();
        step();

        // Plain run; start pulses while busy (cycle 50) and in DONE (edge 96) must be ignored.
        run_xform(0, 0, 50, 96, 96, 1'b0);
        check_eq("s0j0_a", cap_a[0], 0);
        check_eq("s0j0_b", cap_b[0], 1);
        check_eq("s0j15_a", cap_a[15], 30);
        check_eq("s0j15_b", cap_b[15], 31);
        check_eq("s2j5_a", cap_a[37], 9);
        check_eq("s2j5_b", cap_b[37], 13);
        check_eq("s2j5_tw", cap_tw[37], 4);
        check_eq("s4j1_a", cap_a[65], 1);
        check_eq("s4j1_b", cap_b[65], 17);
        check_eq("s4j1_tw", cap_tw[65], 1);
        check_eq("s4j15_tw", cap_tw[79], 15);

        // Accepted right away from IDLE; hold 4 cycles mid stage 1.
        run_xform(25, 4, 0, 0, 100, 1'b0);

        // Reset raised mid-transform at cycle 40.
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        for (int c = 1; c <= 40; c++) step();
        check_eq("pre_rst_rd_en", o_rd_en, 1'b1);
        rst = 1'b1;
        #1;
        check_idle_outputs("midrst");
        step();
        rst = 1'b0;
        n_wr = 0;
        n_rd = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            n_wr += int'(o_wr_en);
            n_rd += int'(o_rd_en);
        end
        check_eq("post_rst_wr", n_wr, 0);
        check_eq("post_rst_rd", n_rd, 0);

        // Fresh start repeats the full sequence.
        run_xform(0, 0, 0, 0, 96, 1'b0);

`ifdef FFT_SEQ_INVERSE_EN
        run_xform(0, 0, 0, 0, 96, 1'b1);
        check_eq("inv_s4j0", cap_tw[64], 0);
        check_eq("inv_s4j1", cap_tw[65], 31);
        check_eq("inv_s4j15", cap_tw[79], 17);
        check_eq("inv_s3j1", cap_tw[49], 30);
        check_eq("inv_s3j7", cap_tw[55], 18);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
